// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode definitions: bubble encoding, fetch FSM states and
// default address width.
package instruction_fetch_pkg;

    // Default PC / instruction-memory address width (word addressed).
    localparam int PC_W_DEFAULT = 32;

    // The decoder treats opcode 7'b000_0000 as NOP; the all-zero word is the
    // canonical bubble injected into IF/ID.
    localparam logic [6:0]  NOP_OPCODE = 7'b000_0000;
    localparam logic [31:0] NOP_INSTR  = {25'd0, NOP_OPCODE};

    // REQ   : request outstanding (or about to be issued) at pc.
    // HOLD  : word fetched during a stall is parked in the buffer, no request.
    // DRAIN : request at the old pc is still outstanding after a redirect;
    //         its response must be swallowed before fetching from tgt.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: IR, PC+1 and a valid flag for the decoder.
// Control priority: rst > bubble > load > hold.
module instruction_fetch_if_id_reg
    import instruction_fetch_pkg::*;
#(
    parameter int          PC_W   = PC_W_DEFAULT,
    parameter logic [31:0] NOP_IR = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [31:0]     ir_d,
    input  logic [PC_W-1:0] pc_1_d,
    output logic [31:0]     ir,
    output logic [PC_W-1:0] pc_1,
    output logic            ir_valid
);

    // Register update; a bubble replaces the instruction with NOP and clears
    // valid but leaves PC_1 alone, since nothing downstream uses it when
    // ir_valid=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir       <= NOP_IR;
            pc_1     <= '0;
            ir_valid <= 1'b0;
        end else if (bubble) begin
            ir       <= NOP_IR;
            ir_valid <= 1'b0;
        end else if (load) begin
            ir       <= ir_d;
            pc_1     <= pc_1_d;
            ir_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, talks to instruction memory over a
// req/ack handshake and fills the IF/ID register for decode.
//
// Memory handshake: imem_req=1 presents imem_addr; the address is held
// constant until imem_ack=1, which may arrive in the same cycle as the
// request or any number of cycles later. imem_ack/imem_rdata are only
// meaningful while imem_req=1. At most one request is outstanding.
//
// Per-cycle priority: rst > redirect > stall > normal fetch.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int               PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP_IR   = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     IR,
    output logic [PC_W-1:0] PC_1,
    output logic            ir_valid,
    output fetch_state_t    fetch_state
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [PC_W-1:0] tgt, tgt_nxt;
    logic [31:0]     buf_ir, buf_ir_nxt;
    logic [PC_W-1:0] buf_pc, buf_pc_nxt;
    logic [PC_W-1:0] pc_inc;

    logic            ifid_load;
    logic            ifid_bubble;
    logic [31:0]     ifid_ir_d;
    logic [PC_W-1:0] ifid_pc_1_d;

    // Wraps modulo 2^PC_W without any flag.
    assign pc_inc = pc + PC_ONE;

    // Memory request: addressed at pc in REQ and DRAIN, idle in HOLD and
    // whenever reset is asserted.
    assign imem_req    = !rst && (state != ST_HOLD);
    assign imem_addr   = pc;
    assign fetch_state = state;

    // FSM, PC, redirect target and stall buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_REQ;
            pc     <= RESET_PC;
            tgt    <= '0;
            buf_ir <= NOP_IR;
            buf_pc <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            tgt    <= tgt_nxt;
            buf_ir <= buf_ir_nxt;
            buf_pc <= buf_pc_nxt;
        end
    end

    // Next-state, PC update and IF/ID control.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        tgt_nxt     = tgt;
        buf_ir_nxt  = buf_ir;
        buf_pc_nxt  = buf_pc;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_ir_d   = imem_rdata;
        ifid_pc_1_d = pc_inc;

        case (state)
            ST_REQ: begin
                if (redirect) begin
                    // Decode holds a wrong-path instruction: squash it.
                    ifid_bubble = 1'b1;
                    if (imem_ack) begin
                        pc_nxt = redirect_pc;
                    end else begin
                        tgt_nxt   = redirect_pc;
                        state_nxt = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_nxt = pc_inc;
                    if (!stall) begin
                        ifid_load = 1'b1;
                    end else begin
                        // Decode cannot take the word yet; park it.
                        buf_ir_nxt = imem_rdata;
                        buf_pc_nxt = pc_inc;
                        state_nxt  = ST_HOLD;
                    end
                end else if (!stall) begin
                    ifid_bubble = 1'b1;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    ifid_bubble = 1'b1;
                    pc_nxt      = redirect_pc;
                    state_nxt   = ST_REQ;
                end else if (!stall) begin
                    ifid_load   = 1'b1;
                    ifid_ir_d   = buf_ir;
                    ifid_pc_1_d = buf_pc;
                    state_nxt   = ST_REQ;
                end
            end

            ST_DRAIN: begin
                ifid_bubble = redirect || !stall;
                if (redirect) begin
                    tgt_nxt = redirect_pc;
                end
                if (imem_ack) begin
                    // Stale response: drop the data, restart at the target.
                    pc_nxt    = redirect ? redirect_pc : tgt;
                    state_nxt = ST_REQ;
                end
            end

            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    instruction_fetch_if_id_reg #(
        .PC_W   (PC_W),
        .NOP_IR (NOP_IR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .ir_d     (ifid_ir_d),
        .pc_1_d   (ifid_pc_1_d),
        .ir       (IR),
        .pc_1     (PC_1),
        .ir_valid (ir_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch. The memory model acks
// whenever ack_en=1 and a request is up, returning addr+32'h100.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IR;
    logic [31:0] PC_1;
    logic        ir_valid;
    fetch_state_t fetch_state;

    logic ack_en;
    logic ack_force;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // Memory model: combinational ack; ack_force injects a stray ack with
    // garbage data regardless of imem_req.
    assign imem_ack   = ack_force | (ack_en & imem_req);
    assign imem_rdata = ack_force ? 32'hDEAD_BEEF : (imem_addr + 32'h100);

    instruction_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .IR          (IR),
        .PC_1        (PC_1),
        .ir_valid    (ir_valid),
        .fetch_state (fetch_state)
    );

    typedef struct {
        logic         rst;
        logic         stall;
        logic         redir;
        logic [31:0]  rpc;
        logic         ack;
        logic         req;
        logic [31:0]  addr;
        logic [31:0]  ir;
        logic [31:0]  pc1;
        logic         v;
        fetch_state_t st;
    } vec_t;

    localparam int NV = 42;
    vec_t vecs[NV];

    function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] rpc, logic a,
                                logic req, logic [31:0] addr, logic [31:0] ir,
                                logic [31:0] pc1, logic v, fetch_state_t st);
        vec_t t;
        t.rst = r; t.stall = s; t.redir = rd; t.rpc = rpc; t.ack = a;
        t.req = req; t.addr = addr; t.ir = ir; t.pc1 = pc1; t.v = v; t.st = st;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(int idx, logic req, logic [31:0] addr, logic [31:0] ir,
                             logic [31:0] pc1, logic v, fetch_state_t st);
        check("imem_req", idx, {31'd0, imem_req}, {31'd0, req});
        check("imem_addr", idx, imem_addr, addr);
        check("IR", idx, IR, ir);
        check("PC_1", idx, PC_1, pc1);
        check("ir_valid", idx, {31'd0, ir_valid}, {31'd0, v});
        check("state", idx, {30'd0, fetch_state}, {30'd0, st});
    endtask

    // Inputs are driven just after the rising edge; outputs are sampled on
    // the falling edge, then the cycle is closed by the next rising edge.
    task automatic drive(logic r, logic s, logic rd, logic [31:0] rpc, logic a, logic af);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc; ack_en = a; ack_force = af;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Cycle-by-cycle vectors: inputs for the cycle, then the outputs
        // expected during that cycle (before the closing edge).
        //               rst   stl   rdr   rpc            ack   req   addr           IR             PC_1   v     state
        // zero-wait back-to-back fetch
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h0,         32'h0, 1'b0, ST_REQ);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1,         32'h100,       32'h1, 1'b1, ST_REQ);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2,         32'h101,       32'h2, 1'b1, ST_REQ);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3,         32'h102,       32'h3, 1'b1, ST_REQ);
        // ack delayed by two cycles: two bubbles, address stable
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         32'h103,       32'h4, 1'b1, ST_REQ);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         32'h0,         32'h4, 1'b0, ST_REQ);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h0,         32'h4, 1'b0, ST_REQ);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h5,         32'h104,       32'h5, 1'b1, ST_REQ);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h5,         32'h0,         32'h5, 1'b0, ST_REQ);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h5,         32'h0,         32'h5, 1'b0, ST_REQ);
        // re-reset, then stall for 3 cycles while IR=0x101
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h6,         32'h105,       32'h6, 1'b1, ST_REQ);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h0,         32'h0, 1'b0, ST_REQ);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1,         32'h100,       32'h1, 1'b1, ST_REQ);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2,         32'h101,       32'h2, 1'b1, ST_REQ);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h3,         32'h101,       32'h2, 1'b1, ST_HOLD);
        vecs[15] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h3,         32'h101,       32'h2, 1'b1, ST_HOLD);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h3,         32'h101,       32'h2, 1'b1, ST_HOLD);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3,         32'h102,       32'h3, 1'b1, ST_REQ);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h103,       32'h4, 1'b1, ST_REQ);
        // redirect to 0x40 while addr 5 is unacked, ack two cycles later
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 32'h40,        1'b0, 1'b1, 32'h5,         32'h104,       32'h5, 1'b1, ST_REQ);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h5,         32'h0,         32'h5, 1'b0, ST_DRAIN);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h5,         32'h0,         32'h5, 1'b0, ST_DRAIN);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h40,        32'h0,         32'h5, 1'b0, ST_REQ);
        vecs[23] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        32'h0,         32'h5, 1'b0, ST_REQ);
        // redirect to 0x80 together with stall: redirect wins
        vecs[24] = mk(1'b0, 1'b1, 1'b1, 32'h80,        1'b1, 1'b1, 32'h41,        32'h140,       32'h41, 1'b1, ST_REQ);
        vecs[25] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h80,        32'h0,         32'h41, 1'b0, ST_REQ);
        vecs[26] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h80,        32'h0,         32'h41, 1'b0, ST_REQ);
        // redirects during DRAIN overwrite tgt; redirect with the ack wins
        vecs[27] = mk(1'b0, 1'b0, 1'b1, 32'h10,        1'b0, 1'b1, 32'h81,        32'h180,       32'h81, 1'b1, ST_REQ);
        vecs[28] = mk(1'b0, 1'b1, 1'b1, 32'h20,        1'b0, 1'b1, 32'h81,        32'h0,         32'h81, 1'b0, ST_DRAIN);
        vecs[29] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h81,        32'h0,         32'h81, 1'b0, ST_DRAIN);
        vecs[30] = mk(1'b0, 1'b0, 1'b1, 32'h30,        1'b1, 1'b1, 32'h81,        32'h0,         32'h81, 1'b0, ST_DRAIN);
        vecs[31] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h30,        32'h0,         32'h81, 1'b0, ST_REQ);
        vecs[32] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h31,        32'h130,       32'h31, 1'b1, ST_REQ);
        // stall with no ack holds IF/ID; then bubbles; then HOLD + redirect
        vecs[33] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h32,        32'h131,       32'h32, 1'b1, ST_REQ);
        vecs[34] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h32,        32'h131,       32'h32, 1'b1, ST_REQ);
        vecs[35] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h32,        32'h0,         32'h32, 1'b0, ST_REQ);
        vecs[36] = mk(1'b0, 1'b0, 1'b1, 32'h50,        1'b1, 1'b0, 32'h33,        32'h0,         32'h32, 1'b0, ST_HOLD);
        vecs[37] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h50,        32'h0,         32'h32, 1'b0, ST_REQ);
        // PC wrap at the maximum address
        vecs[38] = mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h51,        32'h150,       32'h51, 1'b1, ST_REQ);
        vecs[39] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h51, 1'b0, ST_REQ);
        vecs[40] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'hFF,        32'h0, 1'b1, ST_REQ);
        vecs[41] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h1,         32'h100,       32'h1, 1'b1, ST_REQ);

        // Reset for two edges, then check reset state while rst is still high.
        finish_cycle();
        finish_cycle();
        @(negedge clk);
        check_all(-1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, ST_REQ);
        finish_cycle();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack, 1'b0);
            @(negedge clk);
            check_all(i, vecs[i].req, vecs[i].addr, vecs[i].ir, vecs[i].pc1, vecs[i].v, vecs[i].st);
            finish_cycle();
        end

        // Reset in the middle of DRAIN (tgt=0x40) with a stray late ack.
        drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        @(negedge clk);
        check_all(100, 1'b1, 32'h1, 32'h0, 32'h1, 1'b0, ST_REQ);
        finish_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        check_all(101, 1'b0, 32'h1, 32'h0, 32'h1, 1'b0, ST_DRAIN);
        finish_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_all(102, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, ST_REQ);
        finish_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check_all(103, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, ST_REQ);
        finish_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_all(104, 1'b1, 32'h1, 32'h100, 32'h1, 1'b1, ST_REQ);
        finish_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder. It owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Holds the IF/ID pipeline register, which supplies the 32-bit IR and PC+1 to decode.
- Handles stall from the hazard unit, branch/jump redirect from execute, and variable-latency memory, including redirects that arrive while a request is outstanding.

Parameters:
- PC_W, 32, width of PC and memory address (word addressed, PC increments by 1).
- RESET_PC, 0, PC value after reset.
- NOP_IR, 32'h0000_0000, bubble instruction (opcode 7'b000_0000 = NOP).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit; hold IF/ID contents and PC.
- redirect  in  1  execute stage; branch/jump taken this cycle.
- redirect_pc  in  PC_W  target of the taken branch/jump.
- imem_req  out  1  instruction memory request.
- imem_addr  out  PC_W  request address; stable while imem_req=1 and unacked.
- imem_ack  in  1  memory has returned data this cycle; valid only while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- IR  out  32  IF/ID instruction register to the decoder.
- PC_1  out  PC_W  PC+1 of the instruction in IR, used for branch target and JML link.
- ir_valid  out  1  IR holds a real fetched instruction, not a bubble.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=REQ, buffer empty, tgt=0.
  - IR=NOP_IR, PC_1=0, ir_valid=0.
  - imem_req is forced 0 while rst=1.
- States:
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; the fetched word is held in buf_ir/buf_pc.
  - DRAIN: imem_req=1, imem_addr=pc (old address); waiting to discard a stale response.
- Memory protocol:
  - Ack may arrive in the same cycle as req (zero wait) or any number of cycles later.
  - Address must not change until ack.
  - At most one request is outstanding.
- Priority each cycle: rst > redirect > stall > normal.
- REQ, redirect=1:
  - IF/ID <= bubble (IR=NOP_IR, ir_valid=0).
  - If imem_ack=1 in the same cycle: pc<=redirect_pc, stay in REQ; the data is dropped.
  - If imem_ack=0: tgt<=redirect_pc, go to DRAIN.
- REQ, no redirect, imem_ack=1:
  - If stall=0: IR<=imem_rdata, PC_1<=pc+1, ir_valid<=1, pc<=pc+1, stay in REQ. This gives back-to-back fetch, one instruction per cycle with a zero-wait memory.
  - If stall=1: buf_ir<=imem_rdata, pc<=pc+1, go to HOLD. IF/ID holds its contents.
- REQ, no redirect, imem_ack=0:
  - If stall=0: IF/ID <= bubble.
  - If stall=1: IF/ID holds.
- HOLD:
  - redirect=1: discard the buffer, IF/ID <= bubble, pc<=redirect_pc, go to REQ.
  - stall=1: everything holds.
  - stall=0: IR<=buf_ir, PC_1<=pc (already incremented), ir_valid<=1, go to REQ.
- DRAIN:
  - IF/ID <= bubble unless stall=1, in which case it holds.
  - A redirect during DRAIN overwrites tgt.
  - On imem_ack: data discarded, pc<=tgt, or redirect_pc if redirect is asserted in that same cycle; go to REQ.
- Arithmetic: pc+1 is modulo 2^PC_W. At the maximum address it wraps to 0 with no flag.
- Latency: an instruction acked in cycle N is visible on IR in cycle N+1 when stall=0.
- Stall and redirect in the same cycle: redirect wins, because the instruction in decode is wrong-path.

Decomposition:
- Shared package holds:
  - the NOP_IR encoding and the 7-bit NOP opcode, shared with the decoder;
  - the fetch state enum (REQ, HOLD, DRAIN);
  - the PC_W default.
- One sub-module, if_id_reg: IR/PC_1/ir_valid register with load, hold and bubble controls and synchronous reset to bubble.
- The FSM, PC and buffer live in instruction_fetch.

Test Plan:
- Reset, then zero-wait memory returning rdata=addr+32'h100, stall=0:
  - imem_addr sequence is 0,1,2,3.
  - IR is 32'h100,32'h101,... starting one cycle after the first ack.
  - PC_1 is 1,2,3.
  - ir_valid=1 from cycle 2.
- Ack delayed 2 cycles per request: two bubble cycles (IR=0, ir_valid=0) between instructions; imem_addr stays stable while unacked.
- Stall asserted for 3 cycles while IR=32'h101 and the next word is acked:
  - IR/PC_1 hold for 3 cycles, FSM enters HOLD, imem_req=0.
  - On release, IR=32'h102 and PC_1=3.
- Redirect to 0x40 while a request to addr 5 is unacked, ack 2 cycles later:
  - The stale word is discarded and never appears on IR.
  - Next imem_addr=0x40; IR shows only bubbles until the 0x40 word arrives.
- Redirect to 0x80 with stall=1 in the same cycle: IR becomes NOP_IR and ir_valid=0 next cycle; the next request goes to 0x80.
- rst asserted mid-DRAIN with tgt=0x40: next cycle imem_addr=RESET_PC, IR=0, ir_valid=0; the late ack for the old request is ignored.
